// File: rtl/serial_paralelo_lane.sv
// serial_paralelo_lane: per-lane serial-to-parallel converter with COM lock.
// Optional SP_RELOCK_EN: realign after repeated misaligned COM symbols.
module serial_paralelo_lane #(
    parameter logic [7:0]  COM_SYMBOL     = 8'hBC,
    parameter int unsigned BC_LOCK        = 4,
    parameter int unsigned MISALIGN_LIMIT = 2
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active
);
    localparam int CW = $clog2(BC_LOCK + 1);
    localparam logic [CW-1:0] LOCK_N = CW'(BC_LOCK);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ALIGNED,
        S_ACTIVE
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [6:0]    r_sr;
    logic [2:0]    r_bit_cnt, w_bit_nxt;
    logic [CW-1:0] r_com_cnt, w_com_nxt, w_com_inc;
    logic [7:0]    r_data, w_data_nxt;
    logic          r_valid, w_valid_nxt;
    logic          r_strobe, w_strobe_nxt;
    logic          r_active, w_active_nxt;
    logic [7:0]    w_window;
    logic          w_is_com;
    logic          w_boundary;

    assign w_window   = {r_sr, data_in};
    assign w_is_com   = (w_window == COM_SYMBOL);
    assign w_boundary = (r_bit_cnt == 3'd7);
    assign w_com_inc  = r_com_cnt + CW'(1);

`ifdef SP_RELOCK_EN
    localparam int MW = $clog2(MISALIGN_LIMIT + 1);
    localparam logic [MW-1:0] MIS_N = MW'(MISALIGN_LIMIT);
    logic [MW-1:0] r_mis_cnt, w_mis_nxt, w_mis_inc;
    assign w_mis_inc = r_mis_cnt + MW'(1);

    // Misaligned-COM counter register
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) r_mis_cnt <= '0;
        else       r_mis_cnt <= w_mis_nxt;
    end
`else
    logic w_unused_mis;
    assign w_unused_mis = (MISALIGN_LIMIT == 0);
`endif

    // State, shift register, counters and output registers
    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            r_state   <= S_SEARCH;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_com_cnt <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_strobe  <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sr      <= w_window[6:0];
            r_bit_cnt <= w_bit_nxt;
            r_com_cnt <= w_com_nxt;
            r_data    <= w_data_nxt;
            r_valid   <= w_valid_nxt;
            r_strobe  <= w_strobe_nxt;
            r_active  <= w_active_nxt;
        end
    end

    // Next-state logic: sliding search, boundary lock, byte emission
    always_comb begin
        w_state_nxt  = r_state;
        w_bit_nxt    = r_bit_cnt;
        w_com_nxt    = r_com_cnt;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_strobe_nxt = 1'b0;
        w_active_nxt = r_active;
`ifdef SP_RELOCK_EN
        w_mis_nxt    = r_mis_cnt;
`endif
        unique case (r_state)
            S_SEARCH: begin
                if (w_is_com) begin
                    w_bit_nxt = '0;
                    w_com_nxt = CW'(1);
                    if (BC_LOCK == 1) begin
                        w_state_nxt  = S_ACTIVE;
                        w_active_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_ALIGNED;
                    end
                end
            end
            S_ALIGNED: begin
                w_bit_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    if (w_is_com) begin
                        w_com_nxt = w_com_inc;
                        if (w_com_inc == LOCK_N) begin
                            w_state_nxt  = S_ACTIVE;
                            w_active_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_SEARCH;
                        w_com_nxt   = '0;
                    end
                end
            end
            S_ACTIVE: begin
                w_bit_nxt = r_bit_cnt + 3'd1;
                if (w_boundary) begin
                    w_strobe_nxt = 1'b1;
                    w_valid_nxt  = !w_is_com;
                    if (!w_is_com) w_data_nxt = w_window;
`ifdef SP_RELOCK_EN
                    if (w_is_com) w_mis_nxt = '0;
                end else if (w_is_com) begin
                    if (w_mis_inc == MIS_N) begin
                        w_active_nxt = 1'b0;
                        w_state_nxt  = S_ALIGNED;
                        w_com_nxt    = CW'(1);
                        w_bit_nxt    = '0;
                        w_mis_nxt    = '0;
                    end else begin
                        w_mis_nxt = w_mis_inc;
                    end
`endif
                end
            end
            default: w_state_nxt = S_SEARCH;
        endcase
    end

    assign data_out    = r_data;
    assign valid_out   = r_valid;
    assign byte_strobe = r_strobe;
    assign active      = r_active;
endmodule

// File: tb/tb_serial_paralelo_lane.sv
// tb_serial_paralelo_lane: directed table-driven bench for the COM-locking lane.
// Expected values are hand-computed from the lane behaviour.
module tb_serial_paralelo_lane;
    logic       clk_8f = 1'b0;
    logic       reset  = 1'b1;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       byte_strobe;
    logic       active;

    int total = 0;
    int bad   = 0;
    int strobes = 0;

    serial_paralelo_lane dut (
        .clk_8f      (clk_8f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .byte_strobe (byte_strobe),
        .active      (active)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        int         op;
        logic [7:0] din;
        int         nb;
        int         e_stb;
        logic       e_act;
        logic       e_val;
        logic [7:0] e_dat;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input int op, input logic [7:0] d,
                                input int nb, input int s, input logic a,
                                input logic vl, input logic [7:0] dt,
                                input string tag);
        vec_t t;
        t.op = op; t.din = d; t.nb = nb; t.e_stb = s;
        t.e_act = a; t.e_val = vl; t.e_dat = dt; t.tag = tag;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk_8f);
        #1;
        if (byte_strobe === 1'b1) strobes++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        strobes = 0;
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        data_in = 1'b0;
        @(posedge clk_8f);
        @(posedge clk_8f);
        #3;
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        logic [7:0] b;
        logic [4:0] exp6;

        // tests 1 and 2: lock on 4 COMs, then data / idle / data
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, "t1_reset");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t1_bc1");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t1_bc2");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t1_bc3");
        add(1, 8'hBC, 8, 0, 1, 0, 8'h00, "t1_bc4");
        add(1, 8'h5A, 8, 1, 1, 1, 8'h5A, "t2_5a");
        add(1, 8'hBC, 8, 1, 1, 0, 8'h5A, "t2_bc");
        add(1, 8'hC3, 8, 1, 1, 1, 8'hC3, "t2_c3");
        add(1, 8'hFF, 8, 1, 1, 1, 8'hFF, "t2_ff");
        add(1, 8'hBC, 8, 1, 1, 0, 8'hFF, "t2_bc2");
        // test 3: 3-bit offset before the COMs
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, "t3_reset");
        add(2, 8'h05, 3, 0, 0, 0, 8'h00, "t3_pre");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t3_bc1");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t3_bc2");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t3_bc3");
        add(1, 8'hBC, 8, 0, 1, 0, 8'h00, "t3_bc4");
        add(1, 8'h11, 8, 1, 1, 1, 8'h11, "t3_11");
        // test 4: broken COM run restarts the lock count
        add(0, 8'h00, 0, 0, 0, 0, 8'h00, "t4_reset");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc1");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc2");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc3");
        add(1, 8'h00, 8, 0, 0, 0, 8'h00, "t4_00");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc4");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc5");
        add(1, 8'hBC, 8, 0, 0, 0, 8'h00, "t4_bc6");
        add(1, 8'hBC, 8, 0, 1, 0, 8'h00, "t4_bc7");
        add(1, 8'h7E, 8, 1, 1, 1, 8'h7E, "t4_7e");

        foreach (tbl[k]) begin
            v = tbl[k];
            if (v.op == 0) begin
                do_reset();
                check({v.tag, "/stb"}, {7'd0, byte_strobe}, 8'(v.e_stb));
            end else begin
                if (v.op == 1) begin
                    send_byte(v.din);
                end else begin
                    strobes = 0;
                    for (int i = v.nb - 1; i >= 0; i--) send_bit(v.din[i]);
                end
                check({v.tag, "/stb"}, 8'(strobes), 8'(v.e_stb));
            end
            check({v.tag, "/act"}, {7'd0, active}, {7'd0, v.e_act});
            check({v.tag, "/val"}, {7'd0, valid_out}, {7'd0, v.e_val});
            check({v.tag, "/dat"}, data_out, v.e_dat);
        end

        // test 5: asynchronous reset mid-byte, then relock
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        check("t5_lock", {7'd0, active}, 8'd1);
        send_byte(8'hA5);
        check("t5_a5_dat", data_out, 8'hA5);
        check("t5_a5_stb", 8'(strobes), 8'd1);
        b = 8'hA5;
        for (int i = 7; i >= 4; i--) send_bit(b[i]);
        data_in = b[3];
        #3;
        reset = 1'b1;
        #1;
        check("t5_rst_dat", data_out, 8'h00);
        check("t5_rst_val", {7'd0, valid_out}, 8'd0);
        check("t5_rst_stb", {7'd0, byte_strobe}, 8'd0);
        check("t5_rst_act", {7'd0, active}, 8'd0);
        @(posedge clk_8f);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'hBC);
        check("t5_bc3_act", {7'd0, active}, 8'd0);
        send_byte(8'hBC);
        check("t5_bc4_act", {7'd0, active}, 8'd1);
        send_byte(8'h3C);
        check("t5_3c_dat", data_out, 8'h3C);
        check("t5_3c_val", {7'd0, valid_out}, 8'd1);

        // test 6: one extra bit shifts the COM boundary
`ifdef SP_RELOCK_EN
        exp6 = 5'b10001;
`else
        exp6 = 5'b11111;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) send_byte(8'hBC);
        send_byte(8'hBC);
        check("t6_locked", {7'd0, active}, 8'd1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'hBC);
            check($sformatf("t6_bc%0d_act", i + 1), {7'd0, active},
                  {7'd0, exp6[4 - i]});
        end
        send_byte(8'h42);
        check("t6_42_act", {7'd0, active}, 8'd1);
`ifdef SP_RELOCK_EN
        check("t6_42_dat", data_out, 8'h42);
        check("t6_42_stb", 8'(strobes), 8'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
